// File: rtl/ex_flag_writer_if.sv
// EX->MEM stage boundary bundle: EX-side valid/ready handshake with ALU results in,
// MEM-side valid/ready handshake with pc, branch select and flag snapshot out.
interface ex_flag_writer_if #(
   parameter int CSR_WIDTH = 4
);
   logic                 valid_i;
   logic                 ready_o;
   logic [31:0]          result_i;
   logic                 carry_i;
   logic                 ovf_i;
   logic                 flag_we_i;
   logic [31:0]          pc_i;
   logic [1:0]           branch_mux_i;
   logic                 flush_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [31:0]          pc_o;
   logic [1:0]           branch_mux_o;
   logic [CSR_WIDTH-1:0] csr_o;
   logic [CSR_WIDTH-1:0] flags_o;

   // Environment side: drives EX results and the MEM-side ready.
   modport master (
      output valid_i, result_i, carry_i, ovf_i, flag_we_i, pc_i, branch_mux_i,
             flush_i, ready_i,
      input  ready_o, valid_o, pc_o, branch_mux_o, csr_o, flags_o
   );

   // Flag writer side.
   modport slave (
      input  valid_i, result_i, carry_i, ovf_i, flag_we_i, pc_i, branch_mux_i,
             flush_i, ready_i,
      output ready_o, valid_o, pc_o, branch_mux_o, csr_o, flags_o
   );
endinterface

// File: rtl/ex_flag_writer.sv
// EX->MEM flag writer: one-entry valid/ready slot carrying pc, branch select and a
// flag snapshot; owns the architectural flag register, committed when a writer leaves.
module ex_flag_writer #(
   parameter int CSR_WIDTH = 4,
   parameter int CSR_ZERO  = 0,
   parameter int CSR_SIGN  = 1,
   parameter int CSR_CARRY = 2,
   parameter int CSR_OVF   = 3
) (
   input logic              clk_i,
   input logic              rst_ni,
   ex_flag_writer_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   slot_state_e          state_q, state_d;
   logic                 valid_q;
   logic [31:0]          pc_q;
   logic [1:0]           branch_mux_q;
   logic [CSR_WIDTH-1:0] snap_q;
   logic [CSR_WIDTH-1:0] pend_flags_q;
   logic                 pend_we_q;
   logic [CSR_WIDTH-1:0] flags_q;

   logic [CSR_WIDTH-1:0] new_flags;
   logic [CSR_WIDTH-1:0] snap_d;
   logic                 ready;
   logic                 accept;
   logic                 leave;

   // NOTE: every signal written in an always_comb gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      new_flags            = '0;
      new_flags[CSR_ZERO]  = (bus.result_i == 32'h0);
      new_flags[CSR_SIGN]  = bus.result_i[31];
      new_flags[CSR_CARRY] = bus.carry_i;
      new_flags[CSR_OVF]   = bus.ovf_i;
   end

   assign valid_q = (state_q == FULL);
   assign ready   = ~bus.flush_i & (~valid_q | bus.ready_i);
   assign accept  = bus.valid_i & ready;
   assign leave   = valid_q & bus.ready_i & ~bus.flush_i;

   // A pending writer still in the slot is newer than flags_q, even when it
   // commits on the very edge this snapshot is taken.
   assign snap_d = (valid_q & pend_we_q) ? pend_flags_q : flags_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush_i) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (leave && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      bus.valid_o      = valid_q;
      bus.ready_o      = ready;
      bus.pc_o         = pc_q;
      bus.branch_mux_o = branch_mux_q;
      bus.csr_o        = snap_q;
      bus.flags_o      = flags_q;
   end

   // Slot payload and architectural flags. Flush blocks both accept and leave, so a
   // killed writer never reaches flags_q; the stale payload is simply ignored.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q         <= '0;
         branch_mux_q <= '0;
         snap_q       <= '0;
         pend_flags_q <= '0;
         pend_we_q    <= 1'b0;
         flags_q      <= '0;
      end else begin
         if (leave && pend_we_q) begin
            flags_q <= pend_flags_q;
         end
         if (accept) begin
            pc_q         <= bus.pc_i;
            branch_mux_q <= bus.branch_mux_i;
            snap_q       <= snap_d;
            pend_flags_q <= new_flags;
            pend_we_q    <= bus.flag_we_i;
         end
      end
   end

endmodule

// File: tb/tb_ex_flag_writer.sv
// Directed bench for ex_flag_writer: reset, forwarding, backpressure, flush and
// non-writer cases with hand-computed flag values.
module tb_ex_flag_writer;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   ex_flag_writer_if #(.CSR_WIDTH(4)) bus ();

   ex_flag_writer #(.CSR_WIDTH(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic c, input logic o,
                        input logic we, input logic [31:0] pc, input logic [1:0] bm);
      bus.valid_i      = v;
      bus.result_i     = res;
      bus.carry_i      = c;
      bus.ovf_i        = o;
      bus.flag_we_i    = we;
      bus.pc_i         = pc;
      bus.branch_mux_i = bm;
   endtask

   task automatic idle();
      drive(1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b1;
      drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDEAD, 2'b11);

      // Reset held for two edges with valid_i asserted.
      tick();
      tick();
      check("rst_valid_o", 32'(bus.valid_o), 32'h0);
      check("rst_flags_o", 32'(bus.flags_o), 32'h0);
      check("rst_csr_o",   32'(bus.csr_o),   32'h0);
      check("rst_pc_o",    bus.pc_o,         32'h0);
      check("rst_bm_o",    32'(bus.branch_mux_o), 32'h0);
      rst_n = 1'b1;
      idle();
      #1;
      check("rst_ready_o", 32'(bus.ready_o), 32'h1);

      // Zero writer A then branch B.
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 2'b00);
      tick();
      check("zw_a_valid", 32'(bus.valid_o), 32'h1);
      check("zw_a_pc",    bus.pc_o,         32'h100);
      check("zw_a_csr",   32'(bus.csr_o),   32'h0);
      drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h104, 2'b01);
      tick();
      check("zw_b_pc",    bus.pc_o,                 32'h104);
      check("zw_b_bm",    32'(bus.branch_mux_o),    32'h1);
      check("zw_b_csr",   32'(bus.csr_o),           32'h1);
      check("zw_flags",   32'(bus.flags_o),         32'h1);
      idle();
      tick();
      check("zw_drain_valid", 32'(bus.valid_o), 32'h0);
      check("zw_drain_flags", 32'(bus.flags_o), 32'h1);

      // Back-to-back forwarding: B sees A's sign+carry while A commits.
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h200, 2'b00);
      tick();
      check("fw_a_csr", 32'(bus.csr_o), 32'h1);
      drive(1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 32'h204, 2'b11);
      tick();
      check("fw_b_csr",   32'(bus.csr_o),   32'h6);
      check("fw_flags",   32'(bus.flags_o), 32'h6);
      // C follows a non-writer: snapshot comes from the flag register.
      drive(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 32'h208, 2'b00);
      tick();
      check("fw_c_csr", 32'(bus.csr_o), 32'h6);
      // D is a zero+overflow writer that will sit under backpressure.
      drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20C, 2'b10);
      tick();
      check("bp_d_csr", 32'(bus.csr_o), 32'h6);
      check("bp_d_pc",  bus.pc_o,       32'h20C);

      // Backpressure with E waiting on the EX side.
      bus.ready_i = 1'b0;
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h210, 2'b01);
      #1;
      check("bp_ready_o", 32'(bus.ready_o), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_valid_%0d", i), 32'(bus.valid_o), 32'h1);
         check($sformatf("bp_pc_%0d", i),    bus.pc_o,         32'h20C);
         check($sformatf("bp_csr_%0d", i),   32'(bus.csr_o),   32'h6);
         check($sformatf("bp_flags_%0d", i), 32'(bus.flags_o), 32'h6);
      end
      bus.ready_i = 1'b1;
      #1;
      check("bp_release_ready_o", 32'(bus.ready_o), 32'h1);
      tick();
      check("bp_e_pc",    bus.pc_o,         32'h210);
      check("bp_e_csr",   32'(bus.csr_o),   32'h9);
      check("bp_flags",   32'(bus.flags_o), 32'h9);
      idle();
      tick();
      check("bp_drain_valid", 32'(bus.valid_o), 32'h0);
      check("bp_drain_flags", 32'(bus.flags_o), 32'h9);

      // Re-establish flags = zero only.
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h300, 2'b00);
      tick();
      idle();
      tick();
      check("fl_pre_flags", 32'(bus.flags_o), 32'h1);

      // Flush a writer (result=5, ovf=1) while MEM is ready.
      drive(1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h304, 2'b00);
      tick();
      check("fl_a_valid", 32'(bus.valid_o), 32'h1);
      bus.flush_i = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h3F0, 2'b11);
      #1;
      check("fl_ready_o", 32'(bus.ready_o), 32'h0);
      tick();
      check("fl_valid_o", 32'(bus.valid_o), 32'h0);
      check("fl_flags",   32'(bus.flags_o), 32'h1);
      bus.flush_i = 1'b0;
      // Non-writer with zero result after the flush.
      drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h308, 2'b01);
      tick();
      check("fl_next_pc",  bus.pc_o,       32'h308);
      check("fl_next_csr", 32'(bus.csr_o), 32'h1);
      drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'h30C, 2'b10);
      tick();
      check("nw_csr",   32'(bus.csr_o),   32'h1);
      check("nw_flags", 32'(bus.flags_o), 32'h1);
      idle();
      tick();
      check("nw_drain_valid", 32'(bus.valid_o), 32'h0);
      check("nw_drain_flags", 32'(bus.flags_o), 32'h1);

      // Reset mid-operation drops a full slot holding a writer.
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h400, 2'b11);
      tick();
      check("mr_pre_valid", 32'(bus.valid_o), 32'h1);
      rst_n = 1'b0;
      tick();
      check("mr_valid", 32'(bus.valid_o), 32'h0);
      check("mr_flags", 32'(bus.flags_o), 32'h0);
      check("mr_csr",   32'(bus.csr_o),   32'h0);
      rst_n = 1'b1;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
